// File: rtl/alu_op_issue.sv
// alu_op_issue
//   Execute-stage issue buffer. Encodes decoded ALUOp/Funct3/Funct7 into the
//   ALU Operation code and hands it to the ALU through a two-entry skid buffer
//   (main + skid register) with valid/ready handshakes on both sides.
//   Unsupported encodings are passed through as Operation 1111 with
//   illegal=1 and are counted in a saturating debug counter.
//
// Ports
//   clk, reset     clock, asynchronous active-low reset
//   in_valid/in_ready           upstream handshake (in_ready is a flop)
//   ALUOp, Funct3, Funct7       decoded instruction fields
//   flush                       drop buffered and incoming entries
//   out_valid/out_ready         ALU-side handshake
//   Operation, illegal          head entry presented to the ALU
//   illegal_cnt                 saturating count of accepted illegal entries
module alu_op_issue #(
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [CNT_WIDTH-1:0]     illegal_cnt
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = '1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;

    logic [OPCODE_LENGTH-1:0] enc_op, main_op, skid_op;
    logic                     enc_ill, main_ill, skid_ill;
    logic                     accept, pop;
    logic                     load_main, load_skid, move_skid;

    // ---------------- encoder ----------------
    always_comb begin
        enc_op  = OP_ILL;
        enc_ill = 1'b1;
        case (ALUOp)
            2'b00: begin
                enc_op  = OP_ADD;
                enc_ill = 1'b0;
            end
            2'b01: begin
                if (Funct3 == 3'b000) begin
                    enc_op  = OP_EQ;
                    enc_ill = 1'b0;
                end
            end
            default: begin
                // R-type requires Funct7 == 0 (rejects SUB/SRA); I-type ignores it
                if (ALUOp[0] || (Funct7 == 7'd0)) begin
                    case (Funct3)
                        3'b000:  begin enc_op = OP_ADD; enc_ill = 1'b0; end
                        3'b111:  begin enc_op = OP_AND; enc_ill = 1'b0; end
                        3'b110:  begin enc_op = OP_OR;  enc_ill = 1'b0; end
                        default: begin enc_op = OP_ILL; enc_ill = 1'b1; end
                    endcase
                end
            end
        endcase
    end

    // ---------------- handshake / FSM ----------------
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (accept && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // a pop in the flush cycle still counts; only the buffer is emptied
        if (flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            // registered from next state so it never depends on out_ready combinationally
            in_ready <= (state_nxt != FULL);
        end
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_op  <= '0;
            main_ill <= 1'b0;
            skid_op  <= '0;
            skid_ill <= 1'b0;
        end else begin
            if (load_main) begin
                main_op  <= enc_op;
                main_ill <= enc_ill;
            end else if (move_skid) begin
                main_op  <= skid_op;
                main_ill <= skid_ill;
            end
            if (load_skid) begin
                skid_op  <= enc_op;
                skid_ill <= enc_ill;
            end
        end
    end

    assign Operation = main_op;
    assign illegal   = main_ill;

    // ---------------- illegal counter (reset only, survives flush) ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_cnt <= '0;
        end else if (accept && enc_ill && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed vectors with literal expectations, plus a
// queue-based model checked against the DUT on every falling edge.
module tb_alu_op_issue;

    logic       clk, reset;
    logic       in_valid, in_ready;
    logic [1:0] ALUOp;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       flush;
    logic       out_valid, out_ready;
    logic [3:0] Operation;
    logic       illegal;
    logic [7:0] illegal_cnt;

    int tests = 0;
    int fails = 0;

    alu_op_issue #(.OPCODE_LENGTH(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .Operation(Operation), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // entry = {illegal, op}
    function automatic logic [4:0] model_enc(input logic [1:0] a, input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic [4:0] bad;
        bad = 5'b1_1111;
        if (a == 2'd0) return 5'b0_0010;
        if (a == 2'd1) return (f3 == 3'd0) ? 5'b0_1000 : bad;
        if (a == 2'd2 && f7 != 7'd0) return bad;
        if (f3 == 3'd0) return 5'b0_0010;
        if (f3 == 3'd7) return 5'b0_0000;
        if (f3 == 3'd6) return 5'b0_0001;
        return bad;
    endfunction

    logic [4:0] mq[$];
    int         mcnt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            bit acc, pp;
            logic [4:0] e;
            e   = model_enc(ALUOp, Funct3, Funct7);
            acc = in_valid && (mq.size() < 2) && !flush;
            pp  = (mq.size() > 0) && out_ready;
            if (acc && e[4] && mcnt < 255) mcnt = mcnt + 1;
            if (flush) mq.delete();
            else begin
                if (pp) void'(mq.pop_front());
                if (acc) mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            tests++;
            if (out_valid !== (mq.size() > 0)) begin
                fails++;
                $display("FAIL model out_valid: got %b expected %b", out_valid, mq.size() > 0);
            end
            tests++;
            if (in_ready !== (mq.size() < 2)) begin
                fails++;
                $display("FAIL model in_ready: got %b expected %b", in_ready, mq.size() < 2);
            end
            tests++;
            if (illegal_cnt !== 8'(mcnt)) begin
                fails++;
                $display("FAIL model illegal_cnt: got %0d expected %0d", illegal_cnt, mcnt);
            end
            if (mq.size() > 0) begin
                tests++;
                if ({illegal, Operation} !== mq[0]) begin
                    fails++;
                    $display("FAIL model head: got ill=%b op=%b expected ill=%b op=%b",
                             illegal, Operation, mq[0][4], mq[0][3:0]);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] a, input logic [2:0] f3,
                        input logic [6:0] f7, input logic ordy, input logic fl);
        in_valid  = v;
        ALUOp     = a;
        Funct3    = f3;
        Funct7    = f7;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'd0, 3'd0, 7'd0, ordy, 1'b0);
    endtask

    logic [1:0] s_a [4];
    logic [2:0] s_f3[4];
    logic [3:0] s_op[4];

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; ALUOp = '0; Funct3 = '0; Funct7 = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset Operation", Operation, 4'b0000);
        chk("reset illegal", illegal, 0);
        chk("reset illegal_cnt", illegal_cnt, 0);
        chk("reset in_ready", in_ready, 1);
        reset = 1'b1;

        // single R-type ADD
        step(1'b1, 2'b10, 3'b000, 7'd0, 1'b1, 1'b0);
        chk("add out_valid", out_valid, 1);
        chk("add Operation", Operation, 4'b0010);
        chk("add illegal", illegal, 0);
        idle(1'b1);
        chk("add drained", out_valid, 0);

        // stream ANDI, ORI, BEQ, SW at full throughput
        s_a[0] = 2'b11; s_f3[0] = 3'b111; s_op[0] = 4'b0000;
        s_a[1] = 2'b11; s_f3[1] = 3'b110; s_op[1] = 4'b0001;
        s_a[2] = 2'b01; s_f3[2] = 3'b000; s_op[2] = 4'b1000;
        s_a[3] = 2'b00; s_f3[3] = 3'b010; s_op[3] = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s_a[i], s_f3[i], 7'b0100000, 1'b1, 1'b0);
            chk($sformatf("stream op%0d", i), Operation, s_op[i]);
            chk($sformatf("stream in_ready%0d", i), in_ready, 1);
        end
        idle(1'b1);

        // back-pressure: ADD then OR fill the buffer
        step(1'b1, 2'b10, 3'b000, 7'd0, 1'b0, 1'b0);
        chk("bp first in_ready", in_ready, 1);
        step(1'b1, 2'b10, 3'b110, 7'd0, 1'b0, 1'b0);
        chk("bp full in_ready", in_ready, 0);
        chk("bp hold op", Operation, 4'b0010);
        step(1'b1, 2'b11, 3'b111, 7'd0, 1'b0, 1'b0);   // refused while full
        chk("bp still hold", Operation, 4'b0010);
        idle(1'b1);
        chk("bp second op", Operation, 4'b0001);
        chk("bp in_ready back", in_ready, 1);
        idle(1'b1);
        chk("bp drained", out_valid, 0);

        // illegal encodings
        step(1'b1, 2'b10, 3'b000, 7'b0100000, 1'b1, 1'b0);
        chk("sub op", Operation, 4'b1111);
        chk("sub illegal", illegal, 1);
        step(1'b1, 2'b01, 3'b001, 7'd0, 1'b1, 1'b0);
        chk("bne op", Operation, 4'b1111);
        chk("bne illegal", illegal, 1);
        chk("illegal_cnt 2", illegal_cnt, 2);
        idle(1'b1);

        // flush while FULL with an illegal incoming entry
        step(1'b1, 2'b00, 3'b000, 7'd0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 3'b111, 7'd0, 1'b0, 1'b0);
        chk("pre-flush full", in_ready, 0);
        step(1'b1, 2'b01, 3'b111, 7'd0, 1'b0, 1'b1);
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        chk("flush cnt kept", illegal_cnt, 2);
        idle(1'b1);
        chk("flush nothing leaks", out_valid, 0);

        // flush with a pop in the same cycle, from ONE
        step(1'b1, 2'b11, 3'b000, 7'd0, 1'b0, 1'b0);
        step(1'b1, 2'b11, 3'b110, 7'd0, 1'b1, 1'b1);
        chk("flush+pop empty", out_valid, 0);

        // mixed back-pressure pattern, model-checked
        for (int i = 0; i < 12; i++)
            step(1'b1, 2'(i % 4), 3'((i * 3) % 8), (i % 5 == 0) ? 7'h20 : 7'h00,
                 1'(i % 3 != 0), 1'b0);
        repeat (3) idle(1'b1);

        // saturate the counter
        for (int i = 0; i < 300; i++)
            step(1'b1, 2'b01, 3'b101, 7'd0, 1'b1, 1'b0);
        chk("cnt saturated", illegal_cnt, 255);
        idle(1'b1);
        chk("cnt stays saturated", illegal_cnt, 255);

        // asynchronous reset while FULL
        step(1'b1, 2'b00, 3'b000, 7'd0, 1'b0, 1'b0);
        step(1'b1, 2'b11, 3'b110, 7'd0, 1'b0, 1'b0);
        chk("pre-reset full", in_ready, 0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async out_valid", out_valid, 0);
        chk("async illegal_cnt", illegal_cnt, 0);
        chk("async in_ready", in_ready, 1);
        chk("async Operation", Operation, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 2'b11, 3'b111, 7'd0, 1'b1, 1'b0);
        chk("post-reset op", Operation, 4'b0000);
        chk("post-reset valid", out_valid, 1);
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
